// File: rtl/stall_ctrl.sv
// ID-stage stall controller: holds PC and IF/ID while bubbling ID/EX for a
// per-hazard-class number of cycles, then releases the held instruction.
module stall_ctrl #(
    parameter int unsigned LOAD_CYC = 1,
    parameter int unsigned CP0_CYC  = 2,
    parameter int unsigned TRAP_CYC = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HazardCtr,
    input  logic [1:0]  kind,
    input  logic        flush,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_bubble,
    output logic        busy,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        RELEASE
    } state_t;

    localparam logic [2:0] LOAD_N = 3'(LOAD_CYC);
    localparam logic [2:0] CP0_N  = 3'(CP0_CYC);
    localparam logic [2:0] TRAP_N = 3'(TRAP_CYC);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [2:0]  n_sel;
    logic        bubble;

    always_comb begin
        case (kind)
            2'd0:    n_sel = LOAD_N;
            2'd1:    n_sel = CP0_N;
            default: n_sel = TRAP_N;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bubble  = 1'b0;
        case (state_q)
            IDLE: begin
                if (HazardCtr) begin
                    // The detection cycle itself is the first stall cycle, so
                    // STALL only has to cover the remaining N-1.
                    bubble = 1'b1;
                    if (n_sel > 3'd1) begin
                        state_d = STALL;
                        cnt_d   = 2'(n_sel - 3'd2);
                    end else begin
                        state_d = RELEASE;
                    end
                end
            end
            STALL: begin
                bubble = 1'b1;
                if (cnt_q == 2'd0) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Redirect or reset overrides everything: no bubble, nothing counted.
        if (flush || rst) begin
            bubble  = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
        end
        stall_cycles_d = stall_cycles_q + {31'd0, bubble};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign idex_bubble  = bubble;
    assign pc_we        = ~bubble;
    assign ifid_we      = ~bubble;
    assign busy         = (state_q != IDLE) && !rst;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl with default parameters (1/2/3 stall cycles).
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        HazardCtr;
    logic [1:0]  kind;
    logic        flush;
    logic        pc_we;
    logic        ifid_we;
    logic        idex_bubble;
    logic        busy;
    logic [31:0] stall_cycles;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // {pc_we, ifid_we, idex_bubble, busy}
    logic [3:0]  outs;
    assign outs = {pc_we, ifid_we, idex_bubble, busy};

    localparam logic [3:0] PASS_IDLE = 4'b1100;
    localparam logic [3:0] PASS_BUSY = 4'b1101;
    localparam logic [3:0] STALL_IDL = 4'b0010;
    localparam logic [3:0] STALL_BSY = 4'b0011;

    stall_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .HazardCtr    (HazardCtr),
        .kind         (kind),
        .flush        (flush),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .idex_bubble  (idex_bubble),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs mid-low-phase, then settle for sampling.
    task automatic step(input logic r, input logic h, input logic [1:0] k, input logic f);
        @(negedge clk);
        rst = r; HazardCtr = h; kind = k; flush = f;
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        n_tests++;
        if (outs !== PASS_IDLE) begin n_fail++; $display("FAIL reset_during_outs got %b exp %b", outs, PASS_IDLE); end
        step(1'b0, 1'b0, 2'd0, 1'b0);
        n_tests++;
        if (outs !== PASS_IDLE) begin n_fail++; $display("FAIL reset_after_outs got %b exp %b", outs, PASS_IDLE); end
        n_tests++;
        if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", stall_cycles); end
    endtask

    task automatic test_load();
        do_reset();
        step(1'b0, 1'b1, 2'd0, 1'b0);
        n_tests++;
        if (outs !== STALL_IDL) begin n_fail++; $display("FAIL load_t0 got %b exp %b", outs, STALL_IDL); end
        step(1'b0, 1'b1, 2'd0, 1'b0);
        n_tests++;
        if (outs !== PASS_BUSY) begin n_fail++; $display("FAIL load_release got %b exp %b", outs, PASS_BUSY); end
        step(1'b0, 1'b0, 2'd0, 1'b0);
        n_tests++;
        if (outs !== PASS_IDLE) begin n_fail++; $display("FAIL load_idle got %b exp %b", outs, PASS_IDLE); end
        n_tests++;
        if (stall_cycles !== 32'd1) begin n_fail++; $display("FAIL load_count got %0d exp 1", stall_cycles); end
    endtask

    task automatic test_trap();
        logic [3:0] exp_tbl [5];
        logic       haz_tbl [5];
        exp_tbl = '{STALL_IDL, STALL_BSY, STALL_BSY, PASS_BUSY, PASS_IDLE};
        haz_tbl = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, haz_tbl[i], (i == 0) ? 2'd2 : 2'd0, 1'b0);
            n_tests++;
            if (outs !== exp_tbl[i]) begin n_fail++; $display("FAIL trap_t%0d got %b exp %b", i, outs, exp_tbl[i]); end
        end
        n_tests++;
        if (stall_cycles !== 32'd3) begin n_fail++; $display("FAIL trap_count got %0d exp 3", stall_cycles); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_tbl [6];
        logic       haz_tbl [6];
        logic [1:0] knd_tbl [6];
        exp_tbl = '{STALL_IDL, PASS_BUSY, STALL_IDL, STALL_BSY, PASS_BUSY, PASS_IDLE};
        haz_tbl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        // kind changes to load after the mfc0 is accepted; must not shorten it
        knd_tbl = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, haz_tbl[i], knd_tbl[i], 1'b0);
            n_tests++;
            if (outs !== exp_tbl[i]) begin n_fail++; $display("FAIL b2b_t%0d got %b exp %b", i, outs, exp_tbl[i]); end
        end
        n_tests++;
        if (stall_cycles !== 32'd3) begin n_fail++; $display("FAIL b2b_count got %0d exp 3", stall_cycles); end
    endtask

    task automatic test_flush();
        do_reset();
        step(1'b0, 1'b1, 2'd3, 1'b0);
        n_tests++;
        if (outs !== STALL_IDL) begin n_fail++; $display("FAIL flush_t0 got %b exp %b", outs, STALL_IDL); end
        step(1'b0, 1'b1, 2'd3, 1'b1);
        n_tests++;
        if (outs !== PASS_BUSY) begin n_fail++; $display("FAIL flush_t1 got %b exp %b", outs, PASS_BUSY); end
        step(1'b0, 1'b0, 2'd3, 1'b0);
        n_tests++;
        if (outs !== PASS_IDLE) begin n_fail++; $display("FAIL flush_t2 got %b exp %b", outs, PASS_IDLE); end
        n_tests++;
        if (stall_cycles !== 32'd1) begin n_fail++; $display("FAIL flush_count got %0d exp 1", stall_cycles); end
        // flush in IDLE masks a simultaneous hazard
        step(1'b0, 1'b1, 2'd2, 1'b1);
        n_tests++;
        if (outs !== PASS_IDLE) begin n_fail++; $display("FAIL flush_idle got %b exp %b", outs, PASS_IDLE); end
        step(1'b0, 1'b0, 2'd0, 1'b0);
        n_tests++;
        if (outs !== PASS_IDLE || stall_cycles !== 32'd1) begin
            n_fail++; $display("FAIL flush_idle_after got %b/%0d exp %b/1", outs, stall_cycles, PASS_IDLE);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b0, 1'b1, 2'd2, 1'b0);
        n_tests++;
        if (outs !== STALL_IDL) begin n_fail++; $display("FAIL rstmid_t0 got %b exp %b", outs, STALL_IDL); end
        step(1'b1, 1'b0, 2'd2, 1'b0);
        n_tests++;
        if (outs !== PASS_IDLE) begin n_fail++; $display("FAIL rstmid_t1 got %b exp %b", outs, PASS_IDLE); end
        for (int i = 2; i < 4; i++) begin
            step(1'b0, 1'b0, 2'd0, 1'b0);
            n_tests++;
            if (outs !== PASS_IDLE || stall_cycles !== 32'd0) begin
                n_fail++; $display("FAIL rstmid_t%0d got %b/%0d exp %b/0", i, outs, stall_cycles, PASS_IDLE);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b0, 1'b0, 2'd0, 1'b0);
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_q;
        #1;
        n_tests++;
        if (stall_cycles !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload got %h exp ffffffff", stall_cycles); end
        step(1'b0, 1'b1, 2'd0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        n_tests++;
        if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL wrap_count got %h exp 00000000", stall_cycles); end
    endtask

    initial begin
        rst = 1'b1; HazardCtr = 1'b0; kind = 2'd0; flush = 1'b0;
        test_reset();
        test_load();
        test_trap();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
